// File: rtl/pa_pkg.sv
// Shared constants and the pending-write record used across the add datapath
// (decode, execute, writeback).
package pa_pkg;
  localparam int DATA_W = 32;
  localparam int NREGS  = 32;
  localparam int ADDR_W = $clog2(NREGS);
  localparam int CNT_W  = 32;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } pend_t;
endpackage

// File: rtl/writeback_if.sv
// Write-source bundle into writeback: the ALU offer with its ready reply, and
// the load request.
//
// Handshake: an ALU transfer happens on a rising edge where ex_valid and
// wb_ready are both high. While ex_valid is high and wb_ready is low, the
// master holds ex_dest and ex_result stable. Loads carry no ready and are
// always taken.
interface writeback_if;
  import pa_pkg::*;

  logic              ex_valid;
  logic [ADDR_W-1:0] ex_dest;
  logic [DATA_W-1:0] ex_result;
  logic              wb_ready;
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_dest;
  logic [DATA_W-1:0] ld_data;

  modport master (
    output ex_valid, ex_dest, ex_result, ld_valid, ld_dest, ld_data,
    input  wb_ready
  );

  modport slave (
    input  ex_valid, ex_dest, ex_result, ld_valid, ld_dest, ld_data,
    output wb_ready
  );
endinterface

// File: rtl/regfile_2r1w.sv
// Architectural register file with two combinational read ports and one
// synchronous write port. Register 0 reads as zero and is never written.
module regfile_2r1w
  import pa_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b
);
  logic [DATA_W-1:0] mem [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == '0) ? '0 : mem[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : mem[raddr_b];
endmodule

// File: rtl/writeback.sv
// Writeback stage: arbitrates load vs. ALU writes into a one-deep pending
// latch, commits it to the register file and bypasses it to the read ports.
module writeback
  import pa_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  writeback_if.slave        wb,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic [CNT_W-1:0]  retired
);
  pend_t             pend;
  logic [DATA_W-1:0] rf_data_a;
  logic [DATA_W-1:0] rf_data_b;

  // Loads always win; the ALU simply waits for a cycle with no load.
  assign wb.wb_ready = ~wb.ld_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
    end else if (wb.ld_valid) begin
      pend <= '{valid: 1'b1, dest: wb.ld_dest, data: wb.ld_data};
    end else if (wb.ex_valid) begin
      pend <= '{valid: 1'b1, dest: wb.ex_dest, data: wb.ex_result};
    end else begin
      pend.valid <= 1'b0;
    end
  end

  // Writes to register 0 are dropped by the array but still retire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired <= '0;
    end else if (pend.valid) begin
      retired <= retired + CNT_W'(1);
    end
  end

  regfile_2r1w u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (pend.valid),
    .waddr   (pend.dest),
    .wdata   (pend.data),
    .raddr_a (rd_addr_a),
    .rdata_a (rf_data_a),
    .raddr_b (rd_addr_b),
    .rdata_b (rf_data_b)
  );

  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] rf_data,
    input pend_t             p
  );
    if (addr == '0)                  return '0;
    else if (p.valid && p.dest == addr) return p.data;
    else                             return rf_data;
  endfunction

  assign rd_data_a = read_port(rd_addr_a, rf_data_a, pend);
  assign rd_data_b = read_port(rd_addr_b, rf_data_b, pend);
endmodule

// File: tb/tb_writeback.sv
// Directed bench for writeback: a cycle-by-cycle vector table plus short
// sequences for mid-stream reset and back-to-back bypass.
`timescale 1ns/1ps
module tb_writeback;
  import pa_pkg::*;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic [CNT_W-1:0]  retired;

  writeback_if wif ();

  writeback dut (
    .clk       (clk),
    .rst       (rst),
    .wb        (wif.slave),
    .rd_addr_a (rd_addr_a),
    .rd_data_a (rd_data_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_b (rd_data_b),
    .retired   (retired)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DATA_W-1:0] exp_q[$];

  typedef struct {
    logic              ld_v;
    logic [ADDR_W-1:0] ld_d;
    logic [DATA_W-1:0] ld_x;
    logic              ex_v;
    logic [ADDR_W-1:0] ex_d;
    logic [DATA_W-1:0] ex_x;
    logic [ADDR_W-1:0] ra;
    logic [ADDR_W-1:0] rb;
    logic [DATA_W-1:0] exp_a;
    logic [DATA_W-1:0] exp_b;
    logic              exp_rdy;
    logic [CNT_W-1:0]  exp_ret;
  } vec_t;

  vec_t vecs[21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ld_v, input logic [ADDR_W-1:0] ld_d, input logic [DATA_W-1:0] ld_x,
                       input logic ex_v, input logic [ADDR_W-1:0] ex_d, input logic [DATA_W-1:0] ex_x);
    wif.ld_valid  = ld_v;
    wif.ld_dest   = ld_d;
    wif.ld_data   = ld_x;
    wif.ex_valid  = ex_v;
    wif.ex_dest   = ex_d;
    wif.ex_result = ex_x;
  endtask

  function automatic vec_t mk(input logic ld_v, input int ld_d, input logic [31:0] ld_x,
                              input logic ex_v, input int ex_d, input logic [31:0] ex_x,
                              input int ra, input int rb, input logic [31:0] ea,
                              input logic [31:0] eb, input logic rdy, input int ret);
    vec_t v;
    v.ld_v = ld_v; v.ld_d = ADDR_W'(ld_d); v.ld_x = ld_x;
    v.ex_v = ex_v; v.ex_d = ADDR_W'(ex_d); v.ex_x = ex_x;
    v.ra = ADDR_W'(ra); v.rb = ADDR_W'(rb);
    v.exp_a = ea; v.exp_b = eb; v.exp_rdy = rdy; v.exp_ret = CNT_W'(ret);
    return v;
  endfunction

  initial begin
    // Outputs are checked at the negedge: reads reflect state after the
    // previous posedge; wb_ready reflects this cycle's ld_valid.
    //              ld  dst data         ex  dst data         ra  rb  exp_a        exp_b        rdy ret
    vecs[0]  = mk(0,  0, 0,            0,  0, 0,            0,  1, 0,           0,           1,  0);
    vecs[1]  = mk(0,  0, 0,            1,  5, 42,           5,  0, 0,           0,           1,  0);
    vecs[2]  = mk(0,  0, 0,            0,  0, 0,            5,  0, 42,          0,           1,  0);
    vecs[3]  = mk(0,  0, 0,            0,  0, 0,            5,  0, 42,          0,           1,  1);
    vecs[4]  = mk(1,  3, 7,            1,  4, 9,            3,  4, 0,           0,           0,  1);
    vecs[5]  = mk(0,  0, 0,            1,  4, 9,            3,  4, 7,           0,           1,  1);
    vecs[6]  = mk(0,  0, 0,            0,  0, 0,            3,  4, 7,           9,           1,  2);
    vecs[7]  = mk(0,  0, 0,            0,  0, 0,            3,  4, 7,           9,           1,  3);
    vecs[8]  = mk(0,  0, 0,            1,  0, 32'hFFFFFFFF, 0,  0, 0,           0,           1,  3);
    vecs[9]  = mk(0,  0, 0,            0,  0, 0,            0,  0, 0,           0,           1,  3);
    vecs[10] = mk(0,  0, 0,            0,  0, 0,            0,  0, 0,           0,           1,  4);
    vecs[11] = mk(0,  0, 0,            1,  7, 1,            0,  7, 0,           0,           1,  4);
    vecs[12] = mk(0,  0, 0,            1,  7, 2,            0,  7, 0,           1,           1,  4);
    vecs[13] = mk(0,  0, 0,            1,  7, 3,            0,  7, 0,           2,           1,  5);
    vecs[14] = mk(0,  0, 0,            0,  0, 0,            0,  7, 0,           3,           1,  6);
    vecs[15] = mk(0,  0, 0,            0,  0, 0,            0,  7, 0,           3,           1,  7);
    vecs[16] = mk(1, 10, 32'hABCD,     0,  0, 0,           10,  0, 0,           0,           0,  7);
    vecs[17] = mk(1, 11, 32'h1234,     1, 12, 32'h55,      10, 11, 32'hABCD,    0,           0,  7);
    vecs[18] = mk(0,  0, 0,            1, 12, 32'h55,      10, 11, 32'hABCD,    32'h1234,    1,  8);
    vecs[19] = mk(0,  0, 0,            0,  0, 0,           12, 11, 32'h55,      32'h1234,    1,  9);
    vecs[20] = mk(0,  0, 0,            0,  0, 0,           12, 10, 32'h55,      32'hABCD,    1, 10);

    // reset and idle
    rst = 1'b1;
    rd_addr_a = '0;
    rd_addr_b = '0;
    drive(1'b1, '0, '0, 1'b0, '0, '0);
    #1 check("ready_follows_ld_in_reset", 32'(wif.wb_ready), 32'd0);
    wif.ld_valid = 1'b0;
    #1 check("ready_idle_in_reset", 32'(wif.wb_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("retired_after_reset", retired, 32'd0);
    for (int i = 0; i < NREGS; i++) begin
      rd_addr_a = ADDR_W'(i);
      rd_addr_b = ADDR_W'(NREGS - 1 - i);
      #1;
      check("reset_rd_a", rd_data_a, 32'd0);
      check("reset_rd_b", rd_data_b, 32'd0);
    end

    // vector table
    for (int i = 0; i < 21; i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i].ld_v, vecs[i].ld_d, vecs[i].ld_x, vecs[i].ex_v, vecs[i].ex_d, vecs[i].ex_x);
      rd_addr_a = vecs[i].ra;
      rd_addr_b = vecs[i].rb;
      @(negedge clk);
      check($sformatf("vec%0d_rd_a", i), rd_data_a, vecs[i].exp_a);
      check($sformatf("vec%0d_rd_b", i), rd_data_b, vecs[i].exp_b);
      check($sformatf("vec%0d_ready", i), 32'(wif.wb_ready), 32'(vecs[i].exp_rdy));
      check($sformatf("vec%0d_retired", i), retired, vecs[i].exp_ret);
    end

    // reset while a write is pending: it must not commit
    @(posedge clk);
    #1 drive(1'b0, '0, '0, 1'b1, ADDR_W'(9), 32'd55);
    rd_addr_a = ADDR_W'(9);
    rd_addr_b = ADDR_W'(12);
    @(posedge clk);
    #1 drive(1'b0, '0, '0, 1'b0, '0, '0);
    @(negedge clk);
    check("pre_reset_bypass9", rd_data_a, 32'd55);
    #1 rst = 1'b1;
    wif.ld_valid = 1'b1;
    #1;
    check("async_reset_rd9", rd_data_a, 32'd0);
    check("async_reset_rd12", rd_data_b, 32'd0);
    check("async_reset_retired", retired, 32'd0);
    check("ready_low_in_reset", 32'(wif.wb_ready), 32'd0);
    @(posedge clk);
    #1 wif.ld_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_reset_reg9", rd_data_a, 32'd0);
    check("post_reset_reg12", rd_data_b, 32'd0);
    check("post_reset_retired", retired, 32'd0);

    // back-to-back writes to one register: each value bypasses next cycle
    begin
      logic [DATA_W-1:0] val;
      logic [DATA_W-1:0] last;
      last = '0;
      rd_addr_a = '0;
      rd_addr_b = ADDR_W'(20);
      for (int k = 0; k < 4; k++) begin
        @(posedge clk);
        #1;
        val = DATA_W'($urandom_range(1, 32'hFFFF_FFF0));
        drive(1'b0, '0, '0, 1'b1, ADDR_W'(20), val);
        exp_q.push_back(val);
        last = val;
        @(negedge clk);
        if (k > 0) check("b2b_bypass", rd_data_b, exp_q.pop_front());
      end
      @(posedge clk);
      #1 drive(1'b0, '0, '0, 1'b0, '0, '0);
      @(negedge clk);
      check("b2b_bypass_last", rd_data_b, exp_q.pop_front());
      @(posedge clk);
      @(negedge clk);
      check("b2b_array_final", rd_data_b, last);
      check("b2b_retired", retired, 32'd4);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end
endmodule

// File: doc/writeback.md
# writeback

Final stage of the pipelined add datapath, sitting after the execute stage. It accepts the ALU result and destination register index and holds them for one cycle in a pending latch. On the following edge it commits them into a 32 x 32-bit register file. It serves the two operand read ports used by decode, bypassing from the pending latch, arbitrates a second write source (memory load) against the ALU path with a ready handshake, and counts retired writes.

## Interface
- DATA_W, 32, data word width
- NREGS, 32, number of architectural registers
- ADDR_W, 5, register index width (log2 NREGS)
- CNT_W, 32, retire counter width

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- ex_valid  in  1  ALU result offered this cycle
- ex_dest  in  ADDR_W  ALU destination register
- ex_result  in  DATA_W  ALU result (aluresult from execute)
- wb_ready  out  1  ALU offer accepted this cycle
- ld_valid  in  1  load write request (always accepted)
- ld_dest  in  ADDR_W  load destination register
- ld_data  in  DATA_W  load data
- rd_addr_a  in  ADDR_W  read port A index
- rd_data_a  out  DATA_W  read port A data (combinational)
- rd_addr_b  in  ADDR_W  read port B index
- rd_data_b  out  DATA_W  read port B data (combinational)
- retired  out  CNT_W  count of commits since reset

## Operation
- Clock and reset: one clock (clk); reset is asynchronous and active-high (rst).
- Arbitration: load has priority. wb_ready = ~ld_valid, purely combinational. An ALU transfer occurs when ex_valid & wb_ready. If ex_valid is high and wb_ready is low, the upstream holds ex_dest/ex_result stable.
- Capture: on each edge, if ld_valid, the pending latch takes {1, ld_dest, ld_data}. Else, if ex_valid, it takes {1, ex_dest, ex_result}. Otherwise pend_valid goes to 0.
- Commit: on each edge where pend_valid = 1, write pend_data to regs[pend_dest] and increment retired. A write to register 0 is discarded but still counted.
- Capture and commit happen on the same edge, so the latch acts as a one-deep pipeline with no stall.
- Read priority per port:
  - addr == 0 returns 0.
  - Otherwise, if pend_valid and pend_dest == addr, return pend_data (bypass).
  - Otherwise return regs[addr].
- A write arriving at the input this cycle is not bypassed to the read ports. It becomes visible through the bypass one cycle later.
- retired wraps modulo 2^CNT_W with no saturation.

## Timing
- Reset values:
  - All registers 0, pend_valid 0, retired 0.
  - rd_data_a and rd_data_b are 0 for any address.
  - wb_ready follows ld_valid even during reset.
- Reset asserted mid-stream discards the pending entry; it is not committed.
- Latency: input accepted at edge N is visible on the read ports via bypass from edge N onward. It is resident in the array after edge N+1.
- Back-to-back writes to the same dest: the newer value wins the bypass. The array ends with the last value.
- Load and ALU offered in the same cycle: load is captured and the ALU stalls. The ALU is captured on the first cycle ld_valid is low.
- Throughput: one write per cycle, from either source.

## Structure
- Shared package pa_pkg: DATA_W, ADDR_W, NREGS constants, and a pend_t struct {valid, dest, data} shared with decode/execute.
- One sub-module, regfile_2r1w: reset-clearable array with 2 combinational reads and 1 synchronous write. It ignores index 0.
- Arbitration, pending latch, bypass muxes and counter stay in writeback.

## Test plan
- Reset then idle: rst=1 for 2 cycles, release, read all addresses -> every rd_data = 0, retired = 0, wb_ready = 1.
- Single ALU write: ex_valid=1, ex_dest=5, ex_result=42 for one cycle.
  - Next cycle rd_addr_a=5 -> 42 via bypass.
  - Two cycles later, still 42 from the array; retired = 1.
- Load collision: ld_valid=1 (dest 3, data 7) with ex_valid=1 (dest 4, data 9) for one cycle, ex held.
  - wb_ready = 0 in the collision cycle.
  - Then reg3 = 7, reg4 = 9 one cycle after; retired = 2.
- Register 0: ex write dest 0, data 0xFFFFFFFF -> reads of 0 stay 0; retired = 1.
- Back-to-back same dest: dest 7 ← 1, then 2, then 3 on consecutive cycles -> rd_data_b shows 1, 2, 3 on successive cycles; final array value 3.
- Reset mid-operation: assert rst while pend_valid=1 (dest 9, data 55) -> after release reg9 = 0, retired = 0.
